// File: rtl/mem_write_monitor.sv
// mem_write_monitor
//
// Self-checking monitor for the MIPS data-memory write bus. It watches every
// store the core makes and classifies the program run as PASS, FAIL or
// TIMEOUT. The verdict is sticky until reset, so it can drive LEDs on a board
// or be polled by a simulation bench.
//
// A run passes when PASS_DATA is written to PASS_ADDR after at least
// MIN_WRITES legal scratch writes. A store is legal when its address falls in
// the window ALLOW_LO..ALLOW_HI. A run fails on any other store, and also on a
// misaligned store when ALIGN_CHECK is set. A run times out when it spends
// TIMEOUT cycles in RUN without reaching a verdict.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        synchronous active-high reset, returns to RUN and clears
//                everything
//   memwrite     write strobe from the core
//   dataadr      write byte address
//   writedata    write data
//   done         a verdict has been reached (PASS, FAIL or TIMEOUT)
//   pass         the run passed
//   fail         an illegal write was seen
//   timeout      TIMEOUT cycles elapsed with no verdict
//   write_count  legal writes accepted in RUN, saturating
//   cycle_count  cycles spent in RUN, saturating
//   fail_addr    dataadr of the failing write
//   fail_data    writedata of the failing write

module mem_write_monitor #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   PASS_ADDR   = 84,
    parameter logic [WIDTH-1:0]   PASS_DATA   = 0,
    parameter logic [WIDTH-1:0]   ALLOW_LO    = 80,
    parameter logic [WIDTH-1:0]   ALLOW_HI    = 80,
    parameter int unsigned        MIN_WRITES  = 0,
    parameter bit                 ALIGN_CHECK = 1'b1,
    parameter int unsigned        TIMEOUT     = 4096,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memwrite,
    input  logic [WIDTH-1:0]   dataadr,
    input  logic [WIDTH-1:0]   writedata,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [CNT_W-1:0]   write_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [WIDTH-1:0]   fail_addr,
    output logic [WIDTH-1:0]   fail_data
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   writeCount_q, writeCount_d;
    logic [CNT_W-1:0]   cycleCount_q, cycleCount_d;
    logic [WIDTH-1:0]   failAddr_q, failAddr_d;
    logic [WIDTH-1:0]   failData_q, failData_d;
    logic               done_q, pass_q, fail_q, timeout_q;

    logic               misaligned;
    logic               isPassAddr;
    logic               inWindow;
    logic               enoughWrites;
    logic               timeoutHit;

    // Decode the bus into the facts the classification needs. The counters
    // are compared in 32 bits so that MIN_WRITES and TIMEOUT may be any
    // value, including one the counter can never reach.
    always_comb begin
        misaligned   = ALIGN_CHECK && (dataadr[1:0] != 2'b00);
        isPassAddr   = (dataadr == PASS_ADDR);
        inWindow     = (dataadr >= ALLOW_LO) && (dataadr <= ALLOW_HI);
        enoughWrites = (32'(writeCount_q) >= MIN_WRITES);
        timeoutHit   = (TIMEOUT != 0) && (32'(cycleCount_q) == TIMEOUT - 32'd1);
    end

    // Next-state logic. A write is classified by priority: alignment first,
    // then the pass address (even when it also lies inside the scratch
    // window), then the window, and anything else fails. A write verdict
    // beats the timeout in the same cycle. cycle_count only advances on
    // cycles that remain in RUN, so a run that times out reports
    // TIMEOUT-1 cycles.
    always_comb begin
        state_d      = state_q;
        writeCount_d = writeCount_q;
        cycleCount_d = cycleCount_q;
        failAddr_d   = failAddr_q;
        failData_d   = failData_q;

        if (state_q == S_RUN) begin
            if (memwrite) begin
                if (misaligned) begin
                    state_d = S_FAIL;
                end else if (isPassAddr) begin
                    state_d = ((writedata == PASS_DATA) && enoughWrites) ? S_PASS : S_FAIL;
                end else if (inWindow) begin
                    if (writeCount_q != CNT_MAX) begin
                        writeCount_d = writeCount_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_FAIL;
                end
            end

            if ((state_d == S_RUN) && timeoutHit) begin
                state_d = S_TIMEOUT;
            end

            if (state_d == S_FAIL) begin
                failAddr_d = dataadr;
                failData_d = writedata;
            end

            if ((state_d == S_RUN) && (cycleCount_q != CNT_MAX)) begin
                cycleCount_d = cycleCount_q + CNT_W'(1);
            end
        end
    end

    // State and output registers. The verdict flags are decoded from the
    // next state so that they line up with the state register, with no
    // combinational path from the bus to the outputs. Reset overrides every
    // other event in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            writeCount_q <= '0;
            cycleCount_q <= '0;
            failAddr_q   <= '0;
            failData_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            writeCount_q <= writeCount_d;
            cycleCount_q <= cycleCount_d;
            failAddr_q   <= failAddr_d;
            failData_q   <= failData_d;
            done_q       <= (state_d != S_RUN);
            pass_q       <= (state_d == S_PASS);
            fail_q       <= (state_d == S_FAIL);
            timeout_q    <= (state_d == S_TIMEOUT);
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign write_count = writeCount_q;
    assign cycle_count = cycleCount_q;
    assign fail_addr   = failAddr_q;
    assign fail_data   = failData_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor
//
// Four monitors with different parameter sets share one write bus and one
// reset:
//   u0  default parameters
//   u1  TIMEOUT = 16
//   u2  MIN_WRITES = 2
//   u3  window 64..127 that contains PASS_ADDR, no alignment check,
//       no timeout, 4-bit counters
// Directed tasks follow the intended scenarios and check against hand-worked
// constants. A random phase then compares every output of every instance
// against a behavioural model after each clock edge.

module tb_mem_write_monitor;

    localparam int M_RUN  = 0;
    localparam int M_PASS = 1;
    localparam int M_FAIL = 2;
    localparam int M_TMO  = 3;

    localparam int P_LO [4] = '{80, 80, 80, 64};
    localparam int P_HI [4] = '{80, 80, 80, 127};
    localparam int P_MIN[4] = '{0, 0, 2, 0};
    localparam int P_AL [4] = '{1, 1, 1, 0};
    localparam int P_TO [4] = '{4096, 16, 4096, 0};
    localparam int P_CW [4] = '{16, 16, 16, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    logic        obsDone[4];
    logic        obsPass[4];
    logic        obsFail[4];
    logic        obsTmo[4];
    logic [31:0] obsFa[4];
    logic [31:0] obsFd[4];
    logic [31:0] obsWc[4];
    logic [31:0] obsCc[4];
    logic [15:0] wc0, cc0, wc1, cc1, wc2, cc2;
    logic [3:0]  wc3, cc3;

    int          testsRun = 0;
    int          testsFailed = 0;

    int          mSt[4];
    int          mWc[4];
    int          mCc[4];
    logic [31:0] mFa[4];
    logic [31:0] mFd[4];

    always #5 clk = ~clk;

    assign obsWc[0] = {16'b0, wc0};
    assign obsWc[1] = {16'b0, wc1};
    assign obsWc[2] = {16'b0, wc2};
    assign obsWc[3] = {28'b0, wc3};
    assign obsCc[0] = {16'b0, cc0};
    assign obsCc[1] = {16'b0, cc1};
    assign obsCc[2] = {16'b0, cc2};
    assign obsCc[3] = {28'b0, cc3};

    mem_write_monitor u0 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(obsDone[0]), .pass(obsPass[0]), .fail(obsFail[0]), .timeout(obsTmo[0]),
        .write_count(wc0), .cycle_count(cc0), .fail_addr(obsFa[0]), .fail_data(obsFd[0])
    );

    mem_write_monitor #(.TIMEOUT(16)) u1 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(obsDone[1]), .pass(obsPass[1]), .fail(obsFail[1]), .timeout(obsTmo[1]),
        .write_count(wc1), .cycle_count(cc1), .fail_addr(obsFa[1]), .fail_data(obsFd[1])
    );

    mem_write_monitor #(.MIN_WRITES(2)) u2 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(obsDone[2]), .pass(obsPass[2]), .fail(obsFail[2]), .timeout(obsTmo[2]),
        .write_count(wc2), .cycle_count(cc2), .fail_addr(obsFa[2]), .fail_data(obsFd[2])
    );

    mem_write_monitor #(.ALLOW_LO(64), .ALLOW_HI(127), .ALIGN_CHECK(1'b0), .TIMEOUT(0), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(obsDone[3]), .pass(obsPass[3]), .fail(obsFail[3]), .timeout(obsTmo[3]),
        .write_count(wc3), .cycle_count(cc3), .fail_addr(obsFa[3]), .fail_data(obsFd[3])
    );

    // Reference model: applies the classification rules once per clock edge
    // to the run state of each instance.
    task automatic modelStep(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            int nx;
            int maxc;
            bit legal;
            nx = M_RUN;
            legal = 1'b0;
            maxc = (1 << P_CW[i]) - 1;
            if (rst) begin
                mSt[i] = M_RUN; mWc[i] = 0; mCc[i] = 0; mFa[i] = '0; mFd[i] = '0;
            end else if (mSt[i] == M_RUN) begin
                if (mw) begin
                    if (P_AL[i] != 0 && a[1:0] != 2'b00) nx = M_FAIL;
                    else if (a == 32'd84) nx = (d == 32'd0 && mWc[i] >= P_MIN[i]) ? M_PASS : M_FAIL;
                    else if (a >= 32'(P_LO[i]) && a <= 32'(P_HI[i])) legal = 1'b1;
                    else nx = M_FAIL;
                end
                if (nx == M_RUN && P_TO[i] != 0 && mCc[i] == P_TO[i] - 1) nx = M_TMO;
                if (nx == M_FAIL) begin
                    mFa[i] = a; mFd[i] = d;
                end
                if (legal && mWc[i] < maxc) mWc[i]++;
                if (nx == M_RUN && mCc[i] < maxc) mCc[i]++;
                mSt[i] = nx;
            end
        end
    endtask

    // Drive one bus cycle, advance the model, and return #1 after the edge.
    task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
        memwrite = mw;
        dataadr = a;
        writedata = d;
        modelStep(reset, mw, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'd0, 32'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        doReset(2);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obsDone[i] !== 1'b0 || obsPass[i] !== 1'b0 || obsFail[i] !== 1'b0 || obsTmo[i] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset flags u%0d: got d/p/f/t=%b%b%b%b want 0000", i, obsDone[i], obsPass[i], obsFail[i], obsTmo[i]);
            end
            testsRun++;
            if (obsWc[i] !== 32'd0 || obsCc[i] !== 32'd0 || obsFa[i] !== 32'd0 || obsFd[i] !== 32'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset values u%0d: got wc=%0d cc=%0d fa=%0d fd=%0d want 0", i, obsWc[i], obsCc[i], obsFa[i], obsFd[i]);
            end
        end
    endtask

    task automatic test_pass;
        doReset(2);
        applyStimulus(1'b1, 32'd80, 32'd7);
        applyStimulus(1'b1, 32'd80, 32'd3);
        testsRun++;
        if (obsPass[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL pass early: got %b want 0", obsPass[0]); end
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[0] !== 1'b1 || obsDone[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL pass verdict: got p=%b d=%b want 1 1", obsPass[0], obsDone[0]); end
        testsRun++;
        if (obsWc[0] !== 32'd2) begin testsFailed++; $display("[TB] FAIL pass write_count: got %0d want 2", obsWc[0]); end
        testsRun++;
        if (obsFail[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL pass fail flag: got %b want 0", obsFail[0]); end
    endtask

    task automatic test_sticky;
        doReset(1);
        applyStimulus(1'b1, 32'd84, 32'd5);
        testsRun++;
        if (obsFail[0] !== 1'b1 || obsFa[0] !== 32'd84 || obsFd[0] !== 32'd5) begin
            testsFailed++;
            $display("[TB] FAIL bad pass data: got f=%b fa=%0d fd=%0d want 1 84 5", obsFail[0], obsFa[0], obsFd[0]);
        end
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsFail[0] !== 1'b1 || obsPass[0] !== 1'b0 || obsFd[0] !== 32'd5) begin
            testsFailed++;
            $display("[TB] FAIL sticky fail: got f=%b p=%b fd=%0d want 1 0 5", obsFail[0], obsPass[0], obsFd[0]);
        end
    endtask

    task automatic test_bad_addr;
        doReset(1);
        applyStimulus(1'b1, 32'd88, 32'd0);
        testsRun++;
        if (obsFail[0] !== 1'b1 || obsFa[0] !== 32'd88) begin
            testsFailed++;
            $display("[TB] FAIL out of window: got f=%b fa=%0d want 1 88", obsFail[0], obsFa[0]);
        end
        doReset(1);
        applyStimulus(1'b1, 32'd82, 32'd0);
        testsRun++;
        if (obsFail[0] !== 1'b1 || obsFa[0] !== 32'd82) begin
            testsFailed++;
            $display("[TB] FAIL misaligned: got f=%b fa=%0d want 1 82", obsFail[0], obsFa[0]);
        end
        testsRun++;
        if (obsFail[3] !== 1'b0 || obsWc[3] !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL no align check: got f=%b wc=%0d want 0 1", obsFail[3], obsWc[3]);
        end
    endtask

    task automatic test_timeout;
        doReset(1);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 32'd0, 32'd0);
        testsRun++;
        if (obsTmo[1] !== 1'b0 || obsCc[1] !== 32'd15) begin
            testsFailed++;
            $display("[TB] FAIL timeout early: got t=%b cc=%0d want 0 15", obsTmo[1], obsCc[1]);
        end
        applyStimulus(1'b0, 32'd0, 32'd0);
        testsRun++;
        if (obsTmo[1] !== 1'b1 || obsDone[1] !== 1'b1 || obsCc[1] !== 32'd15) begin
            testsFailed++;
            $display("[TB] FAIL timeout: got t=%b d=%b cc=%0d want 1 1 15", obsTmo[1], obsDone[1], obsCc[1]);
        end
        testsRun++;
        if (obsTmo[0] !== 1'b0) begin testsFailed++; $display("[TB] FAIL default timeout: got %b want 0", obsTmo[0]); end
        doReset(1);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[1] !== 1'b1 || obsTmo[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL write beats timeout: got p=%b t=%b want 1 0", obsPass[1], obsTmo[1]);
        end
    endtask

    task automatic test_min_writes;
        doReset(1);
        applyStimulus(1'b1, 32'd80, 32'd1);
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsFail[2] !== 1'b1 || obsWc[2] !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL too few writes: got f=%b wc=%0d want 1 1", obsFail[2], obsWc[2]);
        end
        doReset(1);
        applyStimulus(1'b1, 32'd80, 32'd1);
        applyStimulus(1'b1, 32'd80, 32'd2);
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[2] !== 1'b1 || obsWc[2] !== 32'd2) begin
            testsFailed++;
            $display("[TB] FAIL enough writes: got p=%b wc=%0d want 1 2", obsPass[2], obsWc[2]);
        end
    endtask

    task automatic test_saturation;
        doReset(1);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 32'd100, 32'(k));
        testsRun++;
        if (obsWc[3] !== 32'd15 || obsCc[3] !== 32'd15 || obsFail[3] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL saturation: got wc=%0d cc=%0d f=%b want 15 15 0", obsWc[3], obsCc[3], obsFail[3]);
        end
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[3] !== 1'b1 || obsWc[3] !== 32'd15) begin
            testsFailed++;
            $display("[TB] FAIL pass inside window: got p=%b wc=%0d want 1 15", obsPass[3], obsWc[3]);
        end
    endtask

    task automatic test_reset_priority;
        doReset(1);
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL pre-reset pass: got %b want 1", obsPass[0]); end
        reset = 1'b1;
        applyStimulus(1'b1, 32'd84, 32'd0);
        reset = 1'b0;
        testsRun++;
        if (obsDone[0] !== 1'b0 || obsPass[0] !== 1'b0 || obsFail[0] !== 1'b0 || obsTmo[0] !== 1'b0 ||
            obsWc[0] !== 32'd0 || obsCc[0] !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset wins: got d/p/f/t=%b%b%b%b wc=%0d cc=%0d want 0000 0 0",
                     obsDone[0], obsPass[0], obsFail[0], obsTmo[0], obsWc[0], obsCc[0]);
        end
        applyStimulus(1'b1, 32'd80, 32'd1);
        applyStimulus(1'b1, 32'd84, 32'd0);
        testsRun++;
        if (obsPass[0] !== 1'b1 || obsWc[0] !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL pass after reset: got p=%b wc=%0d want 1 1", obsPass[0], obsWc[0]);
        end
    endtask

    task automatic test_random;
        for (int run = 0; run < 150; run++) begin
            doReset(1);
            for (int c = 0; c < int'($urandom_range(40, 1)); c++) begin
                logic        mw;
                logic [31:0] a;
                logic [31:0] d;
                mw = 1'($urandom_range(1, 0));
                case ($urandom_range(7, 0))
                    0:       a = 32'd84;
                    1:       a = 32'd80;
                    2:       a = 32'd88;
                    3:       a = 32'd64 + 32'($urandom_range(63, 0));
                    4:       a = 32'd80 | 32'($urandom_range(3, 0));
                    5:       a = $urandom;
                    default: a = 32'd80;
                endcase
                d = ($urandom_range(2, 0) == 0) ? 32'd0 : $urandom;
                applyStimulus(mw, a, d);
                for (int i = 0; i < 4; i++) begin
                    logic eDone, ePass, eFail, eTmo;
                    eDone = (mSt[i] != M_RUN);
                    ePass = (mSt[i] == M_PASS);
                    eFail = (mSt[i] == M_FAIL);
                    eTmo  = (mSt[i] == M_TMO);
                    testsRun++;
                    if (obsDone[i] !== eDone || obsPass[i] !== ePass || obsFail[i] !== eFail || obsTmo[i] !== eTmo) begin
                        testsFailed++;
                        $display("[TB] FAIL rand flags u%0d run %0d: got d/p/f/t=%b%b%b%b want %b%b%b%b",
                                 i, run, obsDone[i], obsPass[i], obsFail[i], obsTmo[i], eDone, ePass, eFail, eTmo);
                    end
                    testsRun++;
                    if (obsWc[i] !== 32'(mWc[i]) || obsCc[i] !== 32'(mCc[i])) begin
                        testsFailed++;
                        $display("[TB] FAIL rand counts u%0d run %0d: got wc=%0d cc=%0d want %0d %0d",
                                 i, run, obsWc[i], obsCc[i], mWc[i], mCc[i]);
                    end
                    testsRun++;
                    if (obsFa[i] !== mFa[i] || obsFd[i] !== mFd[i]) begin
                        testsFailed++;
                        $display("[TB] FAIL rand capture u%0d run %0d: got fa=%h fd=%h want %h %h",
                                 i, run, obsFa[i], obsFd[i], mFa[i], mFd[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        memwrite = 1'b0;
        dataadr = '0;
        writedata = '0;
        for (int i = 0; i < 4; i++) begin
            mSt[i] = M_RUN; mWc[i] = 0; mCc[i] = 0; mFa[i] = '0; mFd[i] = '0;
        end
        test_reset();
        test_pass();
        test_sticky();
        test_bad_addr();
        test_timeout();
        test_min_writes();
        test_saturation();
        test_reset_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
